serial_adder: RTL and testbench

Bit-serial unsigned adder that computes A+B one bit per clock, LSB first. Each bit step uses a full-add cell built from two `half_adder` instances and an OR gate, with the carry held in a register between steps. The block sits downstream of the combinational half-adder stage. It is the first sequential arithmetic block in the combinational-to-sequential bring-up path. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: A+B one bit per clock, LSB first, with valid/ready handshakes.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef SERIAL_ADDER_CIN_EN
    ,
    input  logic             Cin
`endif
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   result_cat;
    logic             carry;
    logic [CW-1:0]    count;
    logic             half_s;
    logic             half_c;
    logic             sum_bit;
    logic             carry_c;
    logic             carry_next;
    logic             carry_init;
    logic             accept;
    logic             last_bit;

`ifdef SERIAL_ADDER_CIN_EN
    assign carry_init = Cin;
`else
    assign carry_init = 1'b0;
`endif

    // Full-add cell: two half adders plus an OR on their carries.
    half_adder u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(half_s),  .c(half_c));
    half_adder u_ha1 (.a(half_s),  .b(carry),   .s(sum_bit), .c(carry_c));

    assign carry_next = half_c | carry_c;
    // Concatenate-then-slice so the right shift also works for WIDTH=1.
    assign result_cat = {sum_bit, result};
    assign last_bit   = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        S          = '0;
        Cout       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                S         = result;
                Cout      = carry;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            result <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            result <= '0;
            carry  <= carry_init;
            count  <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            result <= result_cat[WIDTH:1];
            carry  <= carry_next;
            count  <= count + CW'(1);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Carry-in vectors run only when SERIAL_ADDER_CIN_EN is defined.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] S;
    logic       Cout;

    logic       u1_in_valid;
    logic       u1_out_ready;
    logic [0:0] u1_A;
    logic [0:0] u1_B;
    logic       u1_in_ready;
    logic       u1_out_valid;
    logic [0:0] u1_S;
    logic       u1_Cout;

`ifdef SERIAL_ADDER_CIN_EN
    logic       Cin;
    logic       u1_Cin;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef SERIAL_ADDER_CIN_EN
        ,
        .Cin       (Cin)
`endif
    );

    serial_adder #(.WIDTH(1)) dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (u1_in_valid),
        .in_ready  (u1_in_ready),
        .A         (u1_A),
        .B         (u1_B),
        .out_valid (u1_out_valid),
        .out_ready (u1_out_ready),
        .S         (u1_S),
        .Cout      (u1_Cout)
`ifdef SERIAL_ADDER_CIN_EN
        ,
        .Cin       (u1_Cin)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one operand pair, measures latency, optionally stalls the consumer and
    // wiggles the inputs during RUN, then completes the output handshake.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] exp_s, input logic exp_c,
                                 input int hold, input bit disturb);
        int cycles;
        @(negedge clk);
        checkOutput({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        A        = a;
        B        = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 32) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (disturb && out_valid !== 1'b1) begin
                A        = ~A;
                B        = B ^ 8'h5A;
                in_valid = ~in_valid;
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, "_latency"}, 32'(cycles), 32'd8);
        for (int h = 0; h < hold; h++) begin
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_s"}, 32'(S), 32'(exp_s));
            checkOutput({tag, "_hold_cout"}, 32'(Cout), 32'(exp_c));
            checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput({tag, "_s"}, 32'(S), 32'(exp_s));
        checkOutput({tag, "_cout"}, 32'(Cout), 32'(exp_c));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_s_masked"}, 32'(S), 32'd0);
        checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        A            = 8'h00;
        B            = 8'h00;
        u1_in_valid  = 1'b0;
        u1_out_ready = 1'b0;
        u1_A         = 1'b0;
        u1_B         = 1'b0;
`ifdef SERIAL_ADDER_CIN_EN
        Cin          = 1'b0;
        u1_Cin       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_s", 32'(S), 32'd0);
        checkOutput("rst_cout", 32'(Cout), 32'd0);
        checkOutput("rst_w1_in_ready", 32'(u1_in_ready), 32'd1);

        applyStimulus("zero",    8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0);
        applyStimulus("a5_5a",   8'hA5, 8'h5A, 8'hFF, 1'b0, 0, 1'b0);
        applyStimulus("ff_01",   8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b0);
        applyStimulus("80_80",   8'h80, 8'h80, 8'h00, 1'b1, 0, 1'b0);
        applyStimulus("c8_64",   8'hC8, 8'h64, 8'h2C, 1'b1, 0, 1'b0);
        applyStimulus("bkpress", 8'h33, 8'h44, 8'h77, 1'b0, 5, 1'b1);

        // Reset lands on the edge that would process bit 3.
        @(negedge clk);
        A        = 8'hFF;
        B        = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_s", 32'(S), 32'd0);
        checkOutput("midrst_cout", 32'(Cout), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midrst_no_result", 32'(out_valid), 32'd0);
        applyStimulus("12_34", 8'h12, 8'h34, 8'h46, 1'b0, 0, 1'b0);

        @(negedge clk);
        u1_A        = 1'b1;
        u1_B        = 1'b1;
        u1_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u1_in_valid = 1'b0;
        checkOutput("w1_run_valid", 32'(u1_out_valid), 32'd0);
        checkOutput("w1_run_in_ready", 32'(u1_in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("w1_11_valid", 32'(u1_out_valid), 32'd1);
        checkOutput("w1_11_s", 32'(u1_S), 32'd0);
        checkOutput("w1_11_cout", 32'(u1_Cout), 32'd1);
        u1_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u1_out_ready = 1'b0;
        checkOutput("w1_in_ready_back", 32'(u1_in_ready), 32'd1);
        u1_A        = 1'b1;
        u1_B        = 1'b0;
        u1_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u1_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("w1_10_valid", 32'(u1_out_valid), 32'd1);
        checkOutput("w1_10_s", 32'(u1_S), 32'd1);
        checkOutput("w1_10_cout", 32'(u1_Cout), 32'd0);
        u1_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u1_out_ready = 1'b0;

`ifdef SERIAL_ADDER_CIN_EN
        Cin = 1'b1;
        applyStimulus("cin_ff_00", 8'hFF, 8'h00, 8'h00, 1'b1, 0, 1'b0);
        applyStimulus("cin_0f_10", 8'h0F, 8'h10, 8'h20, 1'b0, 0, 1'b0);
        Cin = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
